// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes, legality check and issue-stage FSM states.
package alu_pkg;
    localparam logic [3:0] F_ADD  = 4'h0;
    localparam logic [3:0] F_ADDU = 4'h1;
    localparam logic [3:0] F_SUB  = 4'h2;
    localparam logic [3:0] F_SUBU = 4'h3;
    localparam logic [3:0] F_AND  = 4'h4;
    localparam logic [3:0] F_OR   = 4'h5;
    localparam logic [3:0] F_XOR  = 4'h6;
    localparam logic [3:0] F_NOR  = 4'h7;
    localparam logic [3:0] F_SLT  = 4'hA;
    localparam logic [3:0] F_SLTU = 4'hB;

    typedef enum logic {RUN, HALT} state_t;

    function automatic logic is_legal_f(input logic [3:0] f);
        return f <= F_NOR || f == F_SLT || f == F_SLTU;
    endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREG x N register file, two operand reads plus a debug read, one sync write, r0 fixed at zero.
module regfile_2r1w #(
    parameter int N = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] raddr_a,
    output logic [N-1:0]  rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [N-1:0]  rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata
);
    logic [N-1:0] mem [NREG];

    assign rdata_a  = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b  = (raddr_b == '0) ? '0 : mem[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: operand issue, forwarding and write-back around an external combinational ALU.
// Build option TRAP_ON_OV_EN: signed ADD/SUB overflow suppresses the write and halts the stage.
module alu_issue_wb import alu_pkg::*; #(
    parameter int N = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    input  logic [3:0]    in_F,
    output logic [N-1:0]  alu_A,
    output logic [N-1:0]  alu_B,
    output logic [3:0]    alu_F,
    input  logic [N-1:0]  alu_Y,
    input  logic          alu_Cout,
    input  logic          alu_OV,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [N-1:0]  wb_data,
    output logic          st_ov,
    output logic          st_cout,
    output logic          st_zero,
    output logic          halted,
    input  logic          fault_clr,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);
    state_t        state, state_nx;
    logic          ex_valid, ex_fault, ex_wr, trap_ov, accept;
    logic [AW-1:0] ex_rd;
    logic [N-1:0]  rdata_a, rdata_b, op_a, op_b;

    regfile_2r1w #(.N(N), .NREG(NREG)) u_rf (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(in_rs), .rdata_a(rdata_a),
        .raddr_b(in_rt), .rdata_b(rdata_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .we(ex_wr), .waddr(ex_rd), .wdata(alu_Y)
    );

`ifdef TRAP_ON_OV_EN
    assign trap_ov = alu_OV && (alu_F == F_ADD || alu_F == F_SUB);
`else
    assign trap_ov = 1'b0;
`endif

    assign ex_fault = ex_valid && (!is_legal_f(alu_F) || trap_ov);
    assign ex_wr    = ex_valid && !ex_fault;
    assign in_ready = (state == RUN) && !ex_fault;
    assign accept   = in_valid && in_ready;
    assign halted   = (state == HALT);

    // the op retiring this edge is the only pending writer, so one bypass level suffices
    assign op_a = (ex_wr && ex_rd == in_rs && in_rs != '0) ? alu_Y : rdata_a;
    assign op_b = (ex_wr && ex_rd == in_rt && in_rt != '0) ? alu_Y : rdata_b;

    always_comb begin
        state_nx = (state == RUN) ? (ex_fault ? HALT : RUN) : (fault_clr ? RUN : HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            ex_valid <= 1'b0;
            ex_rd    <= '0;
            alu_A    <= '0;
            alu_B    <= '0;
            alu_F    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            st_ov    <= 1'b0;
            st_cout  <= 1'b0;
            st_zero  <= 1'b0;
        end else begin
            state    <= state_nx;
            ex_valid <= accept;
            wb_valid <= ex_wr;
            if (accept) begin
                alu_A <= op_a;
                alu_B <= op_b;
                alu_F <= in_F;
                ex_rd <= in_rd;
            end
            if (ex_wr) begin
                wb_rd   <= ex_rd;
                wb_data <= alu_Y;
                st_zero <= (alu_Y == '0);
                if (alu_F == F_ADDU || alu_F == F_SUBU) st_cout <= alu_Cout;
            end
            // a trapped overflow is still recorded even though its result is dropped
            st_ov <= st_ov | (ex_valid && alu_OV && (ex_wr || trap_ov));
        end
    end
endmodule
